// File: rtl/roberto_pkg.sv
// rtl/roberto_pkg.sv - shared constants, state codes and helpers for the sensor-frame responder
package roberto_pkg;

  localparam int BYTE_W           = 8;
  localparam int DIST_W           = 10;
  localparam int NUM_SENSORS      = 3;
  localparam int BYTES_PER_SENSOR = 4;
  localparam int FRAME_BYTES      = NUM_SENSORS * BYTES_PER_SENSOR;
  localparam int TIMER_W          = 24;

  localparam logic [BYTE_W-1:0] ASCII_HASH = 8'h23;
  localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_ONE  = 8'h31;
  localparam logic [BYTE_W-1:0] ASCII_NINE = 8'h39;

  localparam logic [1:0] LAST_SENSOR   = 2'(NUM_SENSORS - 1);
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_SENSOR - 1);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_RECEBE      = 4'd1,
    ST_ARMAZENA    = 4'd2,
    ST_PROX_SENSOR = 4'd3,
    ST_DECIDE      = 4'd4,
    ST_ENVIA       = 4'd5,
    ST_PROX_ENVIO  = 4'd6,
    ST_FINAL       = 4'd7,
    ST_ERRO        = 4'd8
  } state_t;

  function automatic logic [BYTE_W-1:0] flag_to_ascii(input logic flag);
    return flag ? ASCII_ONE : ASCII_ZERO;
  endfunction

endpackage

// File: rtl/roberto_respondedor_if.sv
// rtl/roberto_respondedor_if.sv - byte-level serial rx/tx handshake between UART and responder
interface roberto_respondedor_if;
  import roberto_pkg::*;

  logic [BYTE_W-1:0] dado_rx;
  logic              pronto_rx;
  logic              pronto_tx;
  logic              partida_tx;
  logic [BYTE_W-1:0] dado_tx;

  // master is the serial peripheral side, slave is the responder
  modport master (
    output dado_rx,
    output pronto_rx,
    output pronto_tx,
    input  partida_tx,
    input  dado_tx
  );

  modport slave (
    input  dado_rx,
    input  pronto_rx,
    input  pronto_tx,
    output partida_tx,
    output dado_tx
  );

endinterface

// File: rtl/roberto_ascii_acc.sv
// rtl/roberto_ascii_acc.sv - ASCII digit classification and decimal accumulator for one sensor field
module roberto_ascii_acc
  import roberto_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              step,
  input  logic              clear,
  output logic [DIST_W-1:0] acc,
  output logic [1:0]        index,
  output logic              is_digit,
  output logic              is_hash
);

  logic [DIST_W-1:0] acc_q, acc_d;
  logic [1:0]        index_q, index_d;

  assign is_digit = (byte_in >= ASCII_ZERO) && (byte_in <= ASCII_NINE);
  assign is_hash  = (byte_in == ASCII_HASH);
  assign acc      = acc_q;
  assign index    = index_q;

  // Low nibble of '0'..'9' is the digit value; at most 99*10+9 so 10 bits never overflow.
  always_comb begin
    acc_d   = acc_q;
    index_d = index_q;
    if (clear) begin
      acc_d   = '0;
      index_d = '0;
    end else if (step) begin
      acc_d   = (acc_q << 3) + (acc_q << 1) + {{(DIST_W-4){1'b0}}, byte_in[3:0]};
      index_d = index_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      index_q <= '0;
    end else begin
      acc_q   <= acc_d;
      index_q <= index_d;
    end
  end

endmodule

// File: rtl/roberto_respondedor.sv
// rtl/roberto_respondedor.sv - decodes 3-sensor ASCII distance frames and answers one flag byte per sensor
module roberto_respondedor
  import roberto_pkg::*;
#(
  parameter logic [DIST_W-1:0]  THRESHOLD = 10'd100,
  parameter logic [TIMER_W-1:0] TIMEOUT   = 24'd5_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  roberto_respondedor_if.slave  serial,
  output logic [DIST_W-1:0]     distancia_0,
  output logic [DIST_W-1:0]     distancia_1,
  output logic [DIST_W-1:0]     distancia_2,
  output logic                  pronto,
  output logic                  erro,
  output logic [3:0]            db_estado
);

  state_t               state_q, state_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic [1:0]           sensor_q, sensor_d;
  logic [1:0]           tx_idx_q, tx_idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           flags_q, flags_d;
  logic [BYTE_W-1:0]    dado_tx_q, dado_tx_d;
  logic [DIST_W-1:0]    dist_q [NUM_SENSORS];
  logic [DIST_W-1:0]    dist_d [NUM_SENSORS];

  logic                 acc_step;
  logic                 acc_clear;
  logic [DIST_W-1:0]    acc;
  logic [1:0]           byte_idx;
  logic                 is_digit;
  logic                 is_hash;

  function automatic logic pick_flag(input logic [2:0] flags, input logic [1:0] idx);
    case (idx)
      2'd0:    return flags[0];
      2'd1:    return flags[1];
      default: return flags[2];
    endcase
  endfunction

  roberto_ascii_acc u_acc (
    .clock    (clock),
    .reset    (reset),
    .byte_in  (byte_q),
    .step     (acc_step),
    .clear    (acc_clear),
    .acc      (acc),
    .index    (byte_idx),
    .is_digit (is_digit),
    .is_hash  (is_hash)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    sensor_d  = sensor_q;
    tx_idx_d  = tx_idx_q;
    timer_d   = '0;
    flags_d   = flags_q;
    dado_tx_d = dado_tx_q;
    dist_d    = dist_q;
    acc_step  = 1'b0;
    acc_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (serial.pronto_rx && habilita) begin
          byte_d  = serial.dado_rx;
          state_d = ST_ARMAZENA;
        end
      end

      // Timer is zero on entry because every other state forces it to zero.
      ST_RECEBE: begin
        if (serial.pronto_rx) begin
          byte_d  = serial.dado_rx;
          state_d = ST_ARMAZENA;
        end else if (timer_q == TIMEOUT) begin
          state_d = ST_ERRO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_ARMAZENA: begin
        if (byte_idx != LAST_BYTE_IDX) begin
          if (is_digit) begin
            acc_step = 1'b1;
            state_d  = ST_RECEBE;
          end else begin
            state_d  = ST_ERRO;
          end
        end else if (is_hash) begin
          state_d = ST_PROX_SENSOR;
        end else begin
          state_d = ST_ERRO;
        end
      end

      ST_PROX_SENSOR: begin
        acc_clear = 1'b1;
        case (sensor_q)
          2'd0:    dist_d[0] = acc;
          2'd1:    dist_d[1] = acc;
          default: dist_d[2] = acc;
        endcase
        if (sensor_q == LAST_SENSOR) begin
          sensor_d = '0;
          state_d  = ST_DECIDE;
        end else begin
          sensor_d = sensor_q + 2'd1;
          state_d  = ST_RECEBE;
        end
      end

      // The first response byte is built from the fresh compare so it is valid on entry to ENVIA.
      ST_DECIDE: begin
        flags_d   = {dist_q[2] < THRESHOLD, dist_q[1] < THRESHOLD, dist_q[0] < THRESHOLD};
        dado_tx_d = flag_to_ascii(dist_q[0] < THRESHOLD);
        tx_idx_d  = '0;
        state_d   = ST_ENVIA;
      end

      ST_ENVIA: begin
        if (serial.pronto_tx) begin
          state_d = ST_PROX_ENVIO;
        end
      end

      ST_PROX_ENVIO: begin
        if (tx_idx_q == LAST_SENSOR) begin
          tx_idx_d = '0;
          state_d  = ST_FINAL;
        end else begin
          tx_idx_d  = tx_idx_q + 2'd1;
          dado_tx_d = flag_to_ascii(pick_flag(flags_q, tx_idx_q + 2'd1));
          state_d   = ST_ENVIA;
        end
      end

      ST_FINAL: begin
        state_d = ST_IDLE;
      end

      ST_ERRO: begin
        acc_clear = 1'b1;
        sensor_d  = '0;
        tx_idx_d  = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      sensor_q  <= '0;
      tx_idx_q  <= '0;
      timer_q   <= '0;
      flags_q   <= '0;
      dado_tx_q <= '0;
      dist_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      sensor_q  <= sensor_d;
      tx_idx_q  <= tx_idx_d;
      timer_q   <= timer_d;
      flags_q   <= flags_d;
      dado_tx_q <= dado_tx_d;
      dist_q    <= dist_d;
    end
  end

  // Pulse and request outputs decode straight from the state register so reset clears them at once.
  assign serial.partida_tx = (state_q == ST_ENVIA);
  assign serial.dado_tx    = dado_tx_q;
  assign pronto            = (state_q == ST_FINAL);
  assign erro              = (state_q == ST_ERRO);
  assign distancia_0       = dist_q[0];
  assign distancia_1       = dist_q[1];
  assign distancia_2       = dist_q[2];

  always_comb begin
    db_estado = 4'hF;
    case (state_q)
      ST_IDLE, ST_RECEBE, ST_ARMAZENA, ST_PROX_SENSOR, ST_DECIDE,
      ST_ENVIA, ST_PROX_ENVIO, ST_FINAL, ST_ERRO: db_estado = state_q;
      default:                                    db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_roberto_respondedor.sv
// tb/tb_roberto_respondedor.sv - directed self-checking bench for roberto_respondedor
module tb_roberto_respondedor;

  localparam logic [23:0] TB_TIMEOUT = 24'd40;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [9:0] distancia_0, distancia_1, distancia_2;
  logic       pronto, erro;
  logic [3:0] db_estado;
  int         pass_cnt;
  int         total_cnt;

  roberto_respondedor_if sif ();

  roberto_respondedor #(.THRESHOLD(10'd100), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .serial      (sif.slave),
    .distancia_0 (distancia_0),
    .distancia_1 (distancia_1),
    .distancia_2 (distancia_2),
    .pronto      (pronto),
    .erro        (erro),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock);
    sif.dado_rx   = b;
    sif.pronto_rx = 1'b1;
    @(negedge clock);
    sif.pronto_rx = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clock);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic send_and_watch(input logic [7:0] b, output int n_erro, output int n_partida);
    n_erro = 0;
    n_partida = 0;
    send_byte(b, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (erro === 1'b1) n_erro++;
      if (sif.partida_tx === 1'b1) n_partida++;
    end
  endtask

  // Acts as the serial transmitter: accepts three bytes, holding pronto_tx off for `delay` cycles each.
  task automatic get_response(input int delay, input bit inject,
                              output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                              output int n_pronto, output bit got_all, output bit stable);
    logic [7:0] bytes [3];
    int w;
    bytes = '{default: 8'h00};
    got_all = 1'b1;
    stable = 1'b1;
    n_pronto = 0;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (sif.partida_tx !== 1'b1 && w < 300) begin
        @(negedge clock);
        w++;
      end
      if (w >= 300) begin
        got_all = 1'b0;
        break;
      end
      bytes[k] = sif.dado_tx;
      for (int d = 0; d < delay; d++) begin
        @(negedge clock);
        if (sif.partida_tx !== 1'b1 || sif.dado_tx !== bytes[k]) stable = 1'b0;
        if (inject && d == 3) begin
          sif.dado_rx   = "5";
          sif.pronto_rx = 1'b1;
        end else begin
          sif.pronto_rx = 1'b0;
        end
      end
      sif.pronto_tx = 1'b1;
      @(negedge clock);
      sif.pronto_tx = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) n_pronto++;
    end
    b0 = bytes[0];
    b1 = bytes[1];
    b2 = bytes[2];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++; if (db_estado !== 4'd0) $display("FAIL rst_state got %0d expected 0", db_estado); else pass_cnt++;
    total_cnt++; if (sif.partida_tx !== 1'b0) $display("FAIL rst_partida got %0b expected 0", sif.partida_tx); else pass_cnt++;
    total_cnt++; if (sif.dado_tx !== 8'h00) $display("FAIL rst_dado_tx got %0h expected 0", sif.dado_tx); else pass_cnt++;
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== 30'd0) $display("FAIL rst_dist got %0h expected 0", {distancia_0, distancia_1, distancia_2}); else pass_cnt++;
    total_cnt++; if ({pronto, erro} !== 2'b00) $display("FAIL rst_pulses got %0b expected 0", {pronto, erro}); else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [7:0] b0, b1, b2;
    int np;
    bit ok, st;
    habilita = 1'b1;
    send_str("050#120#099#", 2);
    get_response(5, 1'b0, b0, b1, b2, np, ok, st);
    total_cnt++; if (!ok) $display("FAIL basic_tx_seen got %0d expected 1", ok); else pass_cnt++;
    total_cnt++; if (distancia_0 !== 10'd50) $display("FAIL basic_d0 got %0d expected 50", distancia_0); else pass_cnt++;
    total_cnt++; if (distancia_1 !== 10'd120) $display("FAIL basic_d1 got %0d expected 120", distancia_1); else pass_cnt++;
    total_cnt++; if (distancia_2 !== 10'd99) $display("FAIL basic_d2 got %0d expected 99", distancia_2); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h313031) $display("FAIL basic_tx got %0h expected 313031", {b0, b1, b2}); else pass_cnt++;
    total_cnt++; if (np !== 1) $display("FAIL basic_pronto got %0d expected 1", np); else pass_cnt++;
    total_cnt++; if (db_estado !== 4'd0) $display("FAIL basic_idle got %0d expected 0", db_estado); else pass_cnt++;
  endtask

  task automatic test_habilita();
    logic [7:0] b0, b1, b2;
    int np;
    bit ok, st;
    string s;
    habilita = 1'b0;
    send_byte("1", 2);
    total_cnt++; if (db_estado !== 4'd0) $display("FAIL hab_ignored got %0d expected 0", db_estado); else pass_cnt++;
    habilita = 1'b1;
    s = "100#999#000#";
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 2);
      if (i == 0) habilita = 1'b0;
    end
    get_response(3, 1'b0, b0, b1, b2, np, ok, st);
    habilita = 1'b1;
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== {10'd100, 10'd999, 10'd0}) $display("FAIL hab_dist got %0d %0d %0d expected 100 999 0", distancia_0, distancia_1, distancia_2); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h303031) $display("FAIL hab_tx got %0h expected 303031", {b0, b1, b2}); else pass_cnt++;
    total_cnt++; if (np !== 1) $display("FAIL hab_pronto got %0d expected 1", np); else pass_cnt++;
  endtask

  task automatic test_bad_char();
    logic [7:0] b0, b1, b2;
    int np, ne, npt;
    bit ok, st;
    send_str("05", 2);
    send_and_watch("A", ne, npt);
    total_cnt++; if (ne !== 1) $display("FAIL bad_digit_erro got %0d expected 1", ne); else pass_cnt++;
    total_cnt++; if (npt !== 0) $display("FAIL bad_digit_partida got %0d expected 0", npt); else pass_cnt++;
    total_cnt++; if (db_estado !== 4'd0) $display("FAIL bad_digit_idle got %0d expected 0", db_estado); else pass_cnt++;
    total_cnt++; if (distancia_0 !== 10'd100) $display("FAIL bad_digit_d0 got %0d expected 100", distancia_0); else pass_cnt++;
    send_str("012", 2);
    send_and_watch("X", ne, npt);
    total_cnt++; if (ne !== 1) $display("FAIL bad_hash_erro got %0d expected 1", ne); else pass_cnt++;
    send_str("200#060#150#", 2);
    get_response(4, 1'b0, b0, b1, b2, np, ok, st);
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== {10'd200, 10'd60, 10'd150}) $display("FAIL bad_recover_dist got %0d %0d %0d expected 200 60 150", distancia_0, distancia_1, distancia_2); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h303130) $display("FAIL bad_recover_tx got %0h expected 303130", {b0, b1, b2}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k_err;
    send_str("050#1", 2);
    send_byte("2", 0);
    k_err = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (erro === 1'b1 && k_err < 0) k_err = k;
    end
    total_cnt++; if (k_err < int'(TB_TIMEOUT) || k_err > int'(TB_TIMEOUT) + 3) $display("FAIL timeout_cycle got %0d expected %0d..%0d", k_err, TB_TIMEOUT, TB_TIMEOUT + 3); else pass_cnt++;
    total_cnt++; if (distancia_0 !== 10'd50) $display("FAIL timeout_d0 got %0d expected 50", distancia_0); else pass_cnt++;
    total_cnt++; if ({distancia_1, distancia_2} !== {10'd60, 10'd150}) $display("FAIL timeout_d12 got %0d %0d expected 60 150", distancia_1, distancia_2); else pass_cnt++;
  endtask

  task automatic test_slow_bytes();
    logic [7:0] b0, b1, b2;
    int np;
    bit ok, st;
    send_str("007#008#009#", 30);
    get_response(2, 1'b0, b0, b1, b2, np, ok, st);
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== {10'd7, 10'd8, 10'd9}) $display("FAIL slow_dist got %0d %0d %0d expected 7 8 9", distancia_0, distancia_1, distancia_2); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h313131) $display("FAIL slow_tx got %0h expected 313131", {b0, b1, b2}); else pass_cnt++;
  endtask

  task automatic test_tx_stall();
    logic [7:0] b0, b1, b2;
    int np;
    bit ok, st;
    send_str("010#500#099#", 2);
    get_response(1000, 1'b1, b0, b1, b2, np, ok, st);
    total_cnt++; if (!st) $display("FAIL stall_stable got %0d expected 1", st); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h313031) $display("FAIL stall_tx got %0h expected 313031", {b0, b1, b2}); else pass_cnt++;
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== {10'd10, 10'd500, 10'd99}) $display("FAIL stall_dist got %0d %0d %0d expected 10 500 99", distancia_0, distancia_1, distancia_2); else pass_cnt++;
    total_cnt++; if (np !== 1) $display("FAIL stall_pronto got %0d expected 1", np); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1, b2;
    int np;
    bit ok, st;
    send_str("123#45", 2);
    send_byte("6", 0);
    total_cnt++; if (distancia_0 !== 10'd123) $display("FAIL midrst_pre_d0 got %0d expected 123", distancia_0); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== 30'd0) $display("FAIL midrst_dist got %0h expected 0", {distancia_0, distancia_1, distancia_2}); else pass_cnt++;
    total_cnt++; if ({db_estado, sif.partida_tx, pronto, erro, sif.dado_tx} !== 15'd0) $display("FAIL midrst_outputs got %0h expected 0", {db_estado, sif.partida_tx, pronto, erro, sif.dado_tx}); else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    send_str("321#222#100#", 2);
    get_response(3, 1'b0, b0, b1, b2, np, ok, st);
    total_cnt++; if ({distancia_0, distancia_1, distancia_2} !== {10'd321, 10'd222, 10'd100}) $display("FAIL midrst_fresh_dist got %0d %0d %0d expected 321 222 100", distancia_0, distancia_1, distancia_2); else pass_cnt++;
    total_cnt++; if ({b0, b1, b2} !== 24'h303030) $display("FAIL midrst_fresh_tx got %0h expected 303030", {b0, b1, b2}); else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b1;
    habilita      = 1'b0;
    sif.dado_rx   = 8'h00;
    sif.pronto_rx = 1'b0;
    sif.pronto_tx = 1'b0;
    test_reset();
    test_basic();
    test_habilita();
    test_bad_char();
    test_timeout();
    test_slow_bytes();
    test_tx_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/roberto_respondedor.md
ROBERTO_RESPONDEDOR -- requirements
Module: roberto_respondedor

Interface
REQ-001 SHALL have parameter THRESHOLD, default 10'd100, distance below which a sensor is flagged.
REQ-002 SHALL have parameter TIMEOUT, default 24'd5_000_000, max idle clock cycles between bytes inside a frame.
REQ-003 SHALL have port clock  input  1  system clock; reset reset, asynchronous, active-high; clock clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port habilita  input  1  level; frame reception only starts while high.
REQ-006 SHALL have port dado_rx  input  8  byte from serial receiver, valid when pronto_rx=1.
REQ-007 SHALL have port pronto_rx  input  1  one-cycle pulse per received byte.
REQ-008 SHALL have port pronto_tx  input  1  one-cycle pulse, serial transmitter finished a byte.
REQ-009 SHALL have port partida_tx  output  1  level request to transmit dado_tx.
REQ-010 SHALL have port dado_tx  output  8  response byte.
REQ-011 SHALL have ports distancia_0, distancia_1, distancia_2  output  10 each  last decoded distances.
REQ-012 SHALL have ports pronto, erro  output  1 each  one-cycle completion / error pulses.
REQ-013 SHALL have port db_estado  output  4  current state code.

Function
REQ-014 Frame: 12 bytes = 3 sensors x (3 ASCII digits '0'-'9', MSD first, then '#' 0x23); response: 3 bytes, sensor 0 first.
REQ-015 States/codes: IDLE 0, RECEBE 1, ARMAZENA 2, PROX_SENSOR 3, DECIDE 4, ENVIA 5, PROX_ENVIO 6, FINAL 7, ERRO 8; any other code -> IDLE, db_estado=4'hF.
REQ-016 IDLE: pronto_rx & habilita -> ARMAZENA with byte captured; pronto_rx while habilita=0 ignored.
REQ-017 RECEBE: pronto_rx -> ARMAZENA (byte captured); timeout counter reaching TIMEOUT -> ERRO.
REQ-018 Timeout counter cleared on entry to RECEBE and on every captured byte; counts only in RECEBE.
REQ-019 ARMAZENA, byte index 0-2: digit -> acc = acc*10 + (byte-0x30), index+1, -> RECEBE; non-digit -> ERRO.
REQ-020 ARMAZENA, index 3: '#' -> PROX_SENSOR; anything else -> ERRO.
REQ-021 PROX_SENSOR: distancia_<sensor> <= acc; acc, index <= 0; sensor 2 -> DECIDE, else sensor+1 -> RECEBE.
REQ-022 acc 10-bit unsigned; max 999, no overflow possible.
REQ-023 DECIDE (1 cycle): flag[n] = (distancia_n < THRESHOLD); tx index <= 0; -> ENVIA.
REQ-024 ENVIA: partida_tx=1, dado_tx = flag[tx index] ? 8'h31 : 8'h30; pronto_tx -> PROX_ENVIO.
REQ-025 PROX_ENVIO: tx index 2 -> FINAL, else tx index+1 -> ENVIA.
REQ-026 dado_tx held stable through ENVIA; partida_tx low in every other state.
REQ-027 FINAL: pronto=1 one cycle -> IDLE; ERRO: erro=1 one cycle, acc/indices cleared -> IDLE.
REQ-028 pronto_rx outside IDLE/RECEBE is dropped; pronto_tx outside ENVIA ignored.
REQ-029 On error, distancia_n of sensors already completed in that frame keep their new values; others unchanged.
REQ-030 habilita falling mid-frame does not abort the frame.

Reset
REQ-031 reset: state IDLE; acc, all indices, timeout counter, flags, distancia_0..2, dado_tx = 0; partida_tx, pronto, erro = 0; db_estado = 0.
REQ-032 reset mid-frame or mid-transmission abandons it; next frame starts from byte 0.

Structure
REQ-033 State codes, ASCII constants (0x23, 0x30, 0x31) and frame sizes (3 sensors, 4 bytes) SHALL live in shared package roberto_pkg.
REQ-034 Single sub-module roberto_ascii_acc (digit check + acc*10 accumulate, index counter) is natural; FSM, timeout and tx sequencing stay top-level.

Verification
REQ-035 habilita=1, frame "050#120#099#" -> distancia_0/1/2 = 50/120/99, tx bytes 0x31,0x30,0x31, one pronto pulse.
REQ-036 Frame "05A#..." -> erro pulse after byte 3, no partida_tx, return to IDLE, next valid frame accepted.
REQ-037 "050#12" then silence TIMEOUT+1 cycles -> erro pulse, distancia_0=50, distancia_1 unchanged.
REQ-038 "100#" boundary: distancia=100 -> 0x30; "099#" -> 0x31; "999#" -> 999.
REQ-039 Extra pronto_rx during ENVIA and pronto_tx delayed 1000 cycles -> dado_tx/partida_tx stable, byte dropped, order preserved.
REQ-040 reset asserted during byte 7 -> all outputs 0 immediately; fresh frame decodes correctly.
